imem_fetch_ctrl: RTL and testbench

//   Fetch sequencer for the instruction memory. Owns the PC, waits out the

---
 rtl/imem_fetch_if.sv | 24 ++
 rtl/imem_fetch_ctrl.sv | 114 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// Fetch-side bus bundle: instruction memory read port, redirect input and the
// valid/ready instruction stream toward decode.
interface imem_fetch_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        busy_o;

    modport master (
        output mem_req_o, mem_addr_o, valid_o, pc_o, instr_o, busy_o,
        input  mem_instr_i, redirect_i, redirect_pc_i, ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, valid_o, pc_o, instr_o, busy_o,
        output mem_instr_i, redirect_i, redirect_pc_i, ready_i
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: PC ownership, boot delay, one-deep memory
// pipeline, 2-entry output FIFO and redirect flushing.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd1,
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    imem_fetch_if.master bus
);

    typedef enum logic {ST_BOOT, ST_RUN} state_e;

    state_e      state_q;
    logic [3:0]  boot_cnt_q;
    logic [31:0] pc_q;
    logic        inflight_q;
    logic [31:0] inflight_pc_q;
    logic [1:0]  occ_q;
    logic [1:0]  occ_d;
    logic [31:0] last_pc_q;
    logic [31:0] last_instr_q;
    logic [31:0] ent_pc_q    [2];
    logic [31:0] ent_instr_q [2];

    logic        run;
    logic        pop;
    logic        push;
    logic        req;
    logic [2:0]  credit;
    logic [1:0]  keep;

    assign run    = (state_q == ST_RUN);
    assign pop    = bus.valid_o & bus.ready_i;
    assign push   = inflight_q & ~bus.redirect_i;
    assign keep   = occ_q - {1'b0, pop};
    // Slots committed after this cycle's pop; a request is only issued when
    // its response is guaranteed a free entry.
    assign credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign req    = run & ~bus.redirect_i & (credit < 3'(FIFO_DEPTH));

    assign bus.mem_req_o  = req;
    assign bus.mem_addr_o = pc_q;
    assign bus.busy_o     = ~run;
    assign bus.valid_o    = (occ_q != 2'd0);
    assign bus.pc_o       = bus.valid_o ? ent_pc_q[0]    : last_pc_q;
    assign bus.instr_o    = bus.valid_o ? ent_instr_q[0] : last_instr_q;

    always_comb begin
        occ_d = occ_q;
        if (bus.redirect_i) begin
            occ_d = 2'd0;
        end else begin
            occ_d = keep + {1'b0, push};
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= ST_BOOT;
            boot_cnt_q    <= 4'd0;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            occ_q         <= 2'd0;
            last_pc_q     <= 32'h0;
            last_instr_q  <= 32'h0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    if (boot_cnt_q == 4'(BOOT_CYCLES - 1)) begin
                        state_q <= ST_RUN;
                    end else begin
                        boot_cnt_q <= boot_cnt_q + 4'd1;
                    end
                end
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= ST_BOOT;
            endcase

            if (bus.redirect_i) begin
                pc_q <= bus.redirect_pc_i;
            end else if (req) begin
                pc_q <= pc_q + PC_STEP;
            end

            inflight_q <= req;
            if (req) begin
                inflight_pc_q <= pc_q;
            end

            occ_q <= occ_d;
            if (pop) begin
                last_pc_q    <= ent_pc_q[0];
                last_instr_q <= ent_instr_q[0];
            end
        end
    end

    // NOTE: FIFO payload needs no reset; occ_q alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            ent_pc_q[0]    <= ent_pc_q[1];
            ent_instr_q[0] <= ent_instr_q[1];
        end
        if (push) begin
            ent_pc_q[keep[0]]    <= inflight_pc_q;
            ent_instr_q[keep[0]] <= bus.mem_instr_i;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: scoreboard of expected accepted PCs,
// popped by a monitor on every valid/ready handshake.
module tb_imem_fetch_ctrl;

    logic clk_i;
    logic reset_i;
    int   total;
    int   bad;
    int   cyc;

    logic [31:0] sb_q[$];

    imem_fetch_if bus();

    imem_fetch_ctrl dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'd3) return 32'h0123_4567;
        return a * 32'h1111_1111;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
    endtask

    // Memory model: read data appears the cycle after the request.
    initial begin
        logic        req_s;
        logic [31:0] addr_s;
        bus.mem_instr_i = 32'h0;
        forever begin
            @(negedge clk_i);
            req_s  = bus.mem_req_o;
            addr_s = bus.mem_addr_o;
            @(posedge clk_i);
            #1;
            bus.mem_instr_i = req_s ? mem_f(addr_s) : 32'h0;
        end
    end

    // Monitor: every accepted head must match the next scoreboard entry.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk_i);
            if (reset_i && bus.valid_o && bus.ready_i) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got pc %h expected nothing (cycle %0d)", bus.pc_o, cyc);
                end else begin
                    exp_pc = sb_q.pop_front();
                    check("sb_pc", bus.pc_o, exp_pc);
                    check("sb_instr", bus.instr_o, mem_f(exp_pc));
                end
            end
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = -10;
        reset_i           = 1'b0;
        bus.ready_i       = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;

        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", 32'(bus.valid_o),   32'd0);
        check("rst_req",   32'(bus.mem_req_o), 32'd0);
        check("rst_addr",  bus.mem_addr_o,     32'h0);
        check("rst_busy",  32'(bus.busy_o),    32'd1);
        check("rst_pc",    bus.pc_o,           32'h0);
        check("rst_instr", bus.instr_o,        32'h0);

        // T1/T2/T3: plain stream 0..11, backpressure in the middle
        for (int i = 0; i < 12; i++) sb_q.push_back(32'(i));
        reset_i = 1'b1;
        cyc     = 0;
        #1;
        check("t1_busy_c0", 32'(bus.busy_o),    32'd1);
        check("t1_req_c0",  32'(bus.mem_req_o), 32'd0);
        goto(1); #1;
        check("t1_busy_c1", 32'(bus.busy_o),    32'd1);
        check("t1_req_c1",  32'(bus.mem_req_o), 32'd0);
        goto(2); #1;
        check("t1_req_c2",  32'(bus.mem_req_o), 32'd1);
        check("t1_addr_c2", bus.mem_addr_o,     32'h0);
        check("t1_busy_c2", 32'(bus.busy_o),    32'd0);
        goto(3); #1;
        check("t2_valid_c3", 32'(bus.valid_o), 32'd0);
        goto(4); #1;
        check("t2_valid_c4", 32'(bus.valid_o), 32'd1);
        check("t2_pc_c4",    bus.pc_o,         32'h0);

        goto(10);
        bus.ready_i = 1'b0;
        goto(12); #1;
        check("t3_valid_hold", 32'(bus.valid_o),   32'd1);
        check("t3_pc_hold",    bus.pc_o,           32'd6);
        check("t3_req_low",    32'(bus.mem_req_o), 32'd0);
        goto(15); #1;
        check("t3_pc_hold2",    bus.pc_o,           32'd6);
        check("t3_instr_hold2", bus.instr_o,        mem_f(32'd6));
        check("t3_req_low2",    32'(bus.mem_req_o), 32'd0);
        goto(16);
        bus.ready_i = 1'b1;

        // T4: redirect with one buffered entry and one fetch in flight
        goto(22);
        bus.ready_i       = 1'b0;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h40;
        for (int i = 0; i < 4; i++) sb_q.push_back(32'h40 + 32'(i));
        #1;
        check("t4_req_redir", 32'(bus.mem_req_o), 32'd0);
        goto(23);
        bus.redirect_i = 1'b0;
        bus.ready_i    = 1'b1;
        #1;
        check("t4_req_new",  32'(bus.mem_req_o), 32'd1);
        check("t4_addr_new", bus.mem_addr_o,     32'h40);
        goto(24); #1;
        check("t4_valid_gap", 32'(bus.valid_o), 32'd0);
        check("t4_pc_last",   bus.pc_o,         32'd11);
        goto(25); #1;
        check("t4_valid_tgt", 32'(bus.valid_o), 32'd1);
        check("t4_pc_tgt",    bus.pc_o,         32'h40);

        // T5: fill the FIFO, then redirect in the same cycle as a pop
        goto(28);
        bus.ready_i = 1'b0;
        goto(29); #1;
        check("t5_pc_full",  bus.pc_o,           32'h43);
        check("t5_req_full", 32'(bus.mem_req_o), 32'd0);
        goto(30);
        bus.ready_i       = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h40;
        for (int i = 0; i < 5; i++) sb_q.push_back(32'h40 + 32'(i));
        #1;
        check("t5_req_redir", 32'(bus.mem_req_o), 32'd0);
        goto(31);
        bus.redirect_i = 1'b0;
        goto(32); #1;
        check("t5_valid_gap", 32'(bus.valid_o), 32'd0);
        check("t5_pc_last",   bus.pc_o,         32'h43);
        goto(33); #1;
        check("t5_pc_tgt", bus.pc_o, 32'h40);

        // T6: PC wrap, then asynchronous reset between edges
        goto(37);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFF;
        sb_q.push_back(32'hFFFF_FFFF);
        goto(38);
        bus.redirect_i = 1'b0;
        #1;
        check("t6_addr_top",  bus.mem_addr_o, 32'hFFFF_FFFF);
        goto(39); #1;
        check("t6_req_wrap",  32'(bus.mem_req_o), 32'd1);
        check("t6_addr_wrap", bus.mem_addr_o,     32'h0);
        goto(40); #1;
        check("t6_pc_top", bus.pc_o, 32'hFFFF_FFFF);
        goto(41);
        #2;
        reset_i = 1'b0;
        #1;
        check("t6_arst_valid", 32'(bus.valid_o),   32'd0);
        check("t6_arst_req",   32'(bus.mem_req_o), 32'd0);
        check("t6_arst_busy",  32'(bus.busy_o),    32'd1);
        check("t6_arst_pc",    bus.pc_o,           32'h0);

        repeat (2) @(posedge clk_i);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
